// File: rtl/uart_proto_pkg.sv
// rtl/uart_proto_pkg.sv - host protocol constants and responder state encoding
// Purpose: shared opcode/reply bytes and the 3-bit FSM state type for
//          uart_reg_responder.
// Ports:   none (package).
package uart_proto_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W' addr data
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R' addr
  localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K' after a write
  localparam logic [7:0] RSP_NAK   = 8'h3F;  // '?' for an unknown opcode

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DATA  = 3'd2,
    ST_DO_WRITE  = 3'd3,
    ST_DO_READ   = 3'd4,
    ST_READ_CAP  = 3'd5,
    ST_SEND      = 3'd6,
    ST_SEND_WAIT = 3'd7
  } state_t;

endpackage

// File: rtl/uart_frame_timer.sv
// rtl/uart_frame_timer.sv - 24-bit inter-byte timeout counter
// Purpose: counts clock cycles while enabled; expired is high once the count
//          equals LIMIT and stays high until cleared.
// Ports:   clk, rst (sync, active-high), clear (zero the count),
//          enable (count this cycle), expired (count == LIMIT).
module uart_frame_timer #(
  parameter int unsigned LIMIT = 80000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [23:0] LIMIT_W = 24'(LIMIT);

  logic [23:0] count;

  assign expired = (count == LIMIT_W);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 24'd1;
    end
  end

endmodule

// File: rtl/uart_reg_responder.sv
// rtl/uart_reg_responder.sv - uart byte stream to register strobe responder
// Purpose: decodes 'W addr data' / 'R addr' frames from the uart receiver into
//          register write/read strobes and sends one reply byte per command.
// Ports:   clk, rst (sync, active-high)
//          rx_valid/rx_data/rx_error   - received byte stream from the uart
//          tx_busy/tx_start/tx_data    - uart transmit handshake
//          reg_addr/reg_wdata/reg_we/reg_re/reg_rdata - register port
//          overrun - byte dropped while not accepting; busy - frame in progress
module uart_reg_responder
  import uart_proto_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_error,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       overrun,
  output logic       busy
);

  state_t state;
  logic   is_write;
  logic   rx_byte;
  logic   receiving;
  logic   accepted;
  logic   expired;

  // A byte flagged with a framing error is never used as data.
  assign rx_byte   = rx_valid && !rx_error;
  assign receiving = (state == ST_IDLE) || (state == ST_GET_ADDR) ||
                     (state == ST_GET_DATA);
  assign accepted  = rx_byte && receiving;

  uart_frame_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accepted || (state == ST_IDLE)),
    .enable  ((state == ST_GET_ADDR) || (state == ST_GET_DATA)),
    .expired (expired)
  );

  // Strobes are raised on the transition into DO_WRITE/DO_READ so they are
  // high during those states; this lets read data arrive in READ_CAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      is_write  <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we   <= 1'b0;
      reg_re   <= 1'b0;
      tx_start <= 1'b0;
      overrun  <= rx_byte && !receiving;

      case (state)
        ST_IDLE: begin
          if (rx_byte) begin
            busy <= 1'b1;
            if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
              is_write <= (rx_data == CMD_WRITE);
              state    <= ST_GET_ADDR;
            end else begin
              tx_data <= RSP_NAK;
              state   <= ST_SEND;
            end
          end
        end

        ST_GET_ADDR: begin
          if (rx_error || expired) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            reg_addr <= rx_data;
            if (is_write) begin
              state <= ST_GET_DATA;
            end else begin
              reg_re <= 1'b1;
              state  <= ST_DO_READ;
            end
          end
        end

        ST_GET_DATA: begin
          if (rx_error || expired) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (rx_valid) begin
            reg_wdata <= rx_data;
            reg_we    <= 1'b1;
            state     <= ST_DO_WRITE;
          end
        end

        ST_DO_WRITE: begin
          tx_data <= RSP_ACK;
          state   <= ST_SEND;
        end

        ST_DO_READ: begin
          state <= ST_READ_CAP;
        end

        ST_READ_CAP: begin
          tx_data <= reg_rdata;
          state   <= ST_SEND;
        end

        ST_SEND: begin
          if (!tx_busy) begin
            tx_start <= 1'b1;
            state    <= ST_SEND_WAIT;
          end
        end

        ST_SEND_WAIT: begin
          // tx_start is high only in the first SEND_WAIT cycle, before the
          // uart has raised tx_busy, so tx_busy is not trusted then.
          if (!tx_start && !tx_busy) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_responder.sv
// tb/tb_uart_reg_responder.sv - self-checking bench for uart_reg_responder
module tb_uart_reg_responder;

  localparam int T = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_error = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_reg_responder #(.TIMEOUT_CYCLES(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_error  (rx_error),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Environment: register file answering the cycle after reg_re, and a uart
  // transmitter that is busy for busy_len cycles starting after tx_start.
  logic [7:0] rf [256];
  logic [7:0] ref_mem [256];
  int         busy_cnt = 0;
  int         busy_len = 3;
  logic       force_busy = 1'b0;
  int         cyc = 0;

  always @(posedge clk) begin
    if (reg_we) rf[reg_addr] <= reg_wdata;
    if (reg_re) reg_rdata <= rf[reg_addr];
  end

  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign tx_busy = force_busy || (busy_cnt != 0);

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: event counts and captured values, sampled mid-cycle.
  int         n_we = 0, n_re = 0, n_tx = 0, n_ovr = 0, tx_cyc = 0;
  logic [7:0] we_addr = 0, we_data = 0, re_addr = 0, tx_byte = 0;

  always @(negedge clk) begin
    if (reg_we) begin n_we++; we_addr = reg_addr; we_data = reg_wdata; end
    if (reg_re) begin n_re++; re_addr = reg_addr; end
    if (tx_start) begin n_tx++; tx_byte = tx_data; tx_cyc = cyc; end
    if (overrun) n_ovr++;
  end

  int checks = 0;
  int failures = 0;
  int last_rx_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    last_rx_cyc = cyc;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 5000) begin tick(1); k++; end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_wait busy still 1 after 5000 cycles, required 0", name);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int n, input int gap,
                           input logic [7:0] exp_rsp, input int exp_we, input int exp_re,
                           input int exp_lat);
    int we0, re0, tx0;
    logic [7:0] bytes [3];
    we0 = n_we; re0 = n_re; tx0 = n_tx;
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    for (int i = 0; i < n; i++) begin
      if (i > 0) tick(gap);
      send_byte(bytes[i]);
    end
    wait_idle(name);
    tick(1);
    chk({name, "_tx_count"}, n_tx - tx0, 1);
    chk({name, "_rsp"}, tx_byte, exp_rsp);
    chk({name, "_we_count"}, n_we - we0, exp_we);
    chk({name, "_re_count"}, n_re - re0, exp_re);
    if (exp_we != 0) begin
      chk({name, "_we_addr"}, we_addr, b1);
      chk({name, "_we_data"}, we_data, b2);
    end
    if (exp_re != 0) chk({name, "_re_addr"}, re_addr, b1);
    chk({name, "_latency"}, tx_cyc - last_rx_cyc, exp_lat);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         n;
    logic [7:0] exp_rsp;
    int         exp_we, exp_re, exp_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #20_000_000;
    $display("FAIL global_timeout simulation ran past time limit, required completion");
    $fatal(1);
  end

  initial begin
    int we0, tx0, ovr0, k, gap, idle_wait;
    logic [7:0] a, d, op, exp;

    for (int i = 0; i < 256; i++) begin rf[i] = 8'h00; ref_mem[i] = 8'h00; end

    vecs[0] = '{8'h57, 8'h12, 8'hA5, 3, 8'h4B, 1, 0, 3};
    vecs[1] = '{8'h52, 8'h12, 8'h00, 2, 8'hA5, 0, 1, 4};
    vecs[2] = '{8'h41, 8'h00, 8'h00, 1, 8'h3F, 0, 0, 2};
    vecs[3] = '{8'h57, 8'hFF, 8'h5A, 3, 8'h4B, 1, 0, 3};
    vecs[4] = '{8'h52, 8'hFF, 8'h00, 2, 8'h5A, 0, 1, 4};
    vecs[5] = '{8'h52, 8'h00, 8'h00, 2, 8'h00, 0, 1, 4};
    vecs[6] = '{8'h4B, 8'h00, 8'h00, 1, 8'h3F, 0, 0, 2};
    vecs[7] = '{8'h57, 8'h00, 8'hC3, 3, 8'h4B, 1, 0, 3};
    vecs[8] = '{8'h52, 8'h00, 8'h00, 2, 8'hC3, 0, 1, 4};

    // Reset state
    tick(3);
    chk("reset_outputs", {tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, overrun}, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    // Table: write / read / unknown, first frame with 1000-cycle byte spacing
    for (int i = 0; i < 9; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].n,
                (i == 0) ? 1000 : 2, vecs[i].exp_rsp, vecs[i].exp_we, vecs[i].exp_re,
                vecs[i].exp_lat);
      if (vecs[i].exp_we != 0) ref_mem[vecs[i].b1] = vecs[i].b2;
      tick(3);
    end

    // Timeout mid-frame, then a normal read
    we0 = n_we; tx0 = n_tx;
    send_byte(8'h57); tick(3); send_byte(8'h12);
    tick(T - 10);
    chk("timeout_not_yet", busy, 1);
    tick(15);
    chk("timeout_idle", busy, 0);
    chk("timeout_no_we", n_we - we0, 0);
    chk("timeout_no_tx", n_tx - tx0, 0);
    run_frame("after_timeout", 8'h52, 8'h05, 8'h00, 2, 4, ref_mem[8'h05], 0, 1, 4);
    tick(3);

    // Backpressure on a read reply, plus an overrun byte while in SEND
    tx0 = n_tx; ovr0 = n_ovr;
    force_busy = 1'b1;
    send_byte(8'h52); tick(2); send_byte(8'h12);
    tick(10);
    chk("bp_busy_in_send", busy, 1);
    send_byte(8'h99);
    tick(2);
    chk("bp_overrun_count", n_ovr - ovr0, 1);
    chk("bp_still_busy", busy, 1);
    tick(185);
    chk("bp_no_tx_while_busy", n_tx - tx0, 0);
    force_busy = 1'b0;
    wait_idle("bp");
    tick(1);
    chk("bp_tx_count", n_tx - tx0, 1);
    chk("bp_rsp", tx_byte, ref_mem[8'h12]);
    tick(3);

    // rx_error mid-frame aborts silently
    we0 = n_we; tx0 = n_tx;
    send_byte(8'h57); tick(2); send_byte(8'h12); tick(2);
    rx_error = 1'b1; tick(1); rx_error = 1'b0; tick(1);
    chk("rxerr_idle", busy, 0);
    chk("rxerr_no_we", n_we - we0, 0);
    chk("rxerr_no_tx", n_tx - tx0, 0);
    run_frame("after_rxerr", 8'h57, 8'h21, 8'h7E, 3, 1, 8'h4B, 1, 0, 3);
    ref_mem[8'h21] = 8'h7E;
    tick(3);

    // Byte with simultaneous framing error is discarded
    tx0 = n_tx;
    rx_valid = 1'b1; rx_error = 1'b1; rx_data = 8'h41;
    tick(1);
    rx_valid = 1'b0; rx_error = 1'b0;
    tick(3);
    chk("err_wins_idle", busy, 0);
    chk("err_wins_no_tx", n_tx - tx0, 0);

    // Reset in GET_DATA
    we0 = n_we;
    send_byte(8'h57); tick(2); send_byte(8'h12); tick(2);
    rst = 1'b1; tick(1);
    chk("rst_mid_outputs", {tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, overrun, busy}, 0);
    rst = 1'b0; tick(2);
    chk("rst_mid_no_we", n_we - we0, 0);
    run_frame("after_rst", 8'h57, 8'h33, 8'h44, 3, 2, 8'h4B, 1, 0, 3);
    ref_mem[8'h33] = 8'h44;
    run_frame("after_rst_rd", 8'h52, 8'h33, 8'h00, 2, 2, 8'h44, 0, 1, 4);
    tick(3);

    // Randomized frames against the memory model
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 2);
      a = 8'($urandom);
      d = 8'($urandom);
      gap = $urandom_range(0, 40);
      busy_len = $urandom_range(1, 25);
      if (k == 0) begin
        run_frame($sformatf("rnd%0d_w", it), 8'h57, a, d, 3, gap, 8'h4B, 1, 0, 3);
        ref_mem[a] = d;
      end else if (k == 1) begin
        exp = ref_mem[a];
        run_frame($sformatf("rnd%0d_r", it), 8'h52, a, 8'h00, 2, gap, exp, 0, 1, 4);
      end else begin
        op = 8'($urandom);
        while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
        run_frame($sformatf("rnd%0d_u", it), op, 8'h00, 8'h00, 1, gap, 8'h3F, 0, 0, 2);
      end
      idle_wait = $urandom_range(0, 5);
      tick(idle_wait);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
Byte-level command responder on the parallel side of the uart block. It consumes received bytes (received/rx_byte/recv_error) and decodes a 2/3-byte host protocol into register write/read strobes. Each command gets exactly one reply byte, issued through the uart transmit/tx_byte/is_transmitting handshake. It is the host-facing register access endpoint for the FPGA design.

Parameters:
TIMEOUT_CYCLES, 80000, max clk cycles allowed between bytes of one frame (10 ms at 8 MHz); must be < 2^24
CMD_WRITE, 8'h57, opcode 'W': frame W addr data
CMD_READ, 8'h52, opcode 'R': frame R addr
RSP_ACK, 8'h4B, reply 'K' to a completed write
RSP_NAK, 8'h3F, reply '?' to an unknown opcode

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx_valid  in  1  one-cycle pulse, new byte on rx_data (uart received)
rx_data  in  8  received byte (uart rx_byte)
rx_error  in  1  one-cycle framing-error pulse (uart recv_error)
tx_busy  in  1  uart is_transmitting
tx_start  out  1  one-cycle pulse to uart transmit
tx_data  out  8  reply byte, held stable from tx_start until return to IDLE
reg_addr  out  8  register address
reg_wdata  out  8  register write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid the cycle after reg_re
overrun  out  1  one-cycle pulse: byte received while not accepting, dropped
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE. tx_start, tx_data, reg_addr, reg_wdata, reg_we, reg_re, overrun and timeout counter all 0. busy 0. Reset mid-frame or mid-reply aborts with no strobe. A tx_start already issued is not recalled.
- All outputs registered. reg_we, reg_re, tx_start and overrun are high for exactly one cycle per event.
- States: IDLE, GET_ADDR, GET_DATA, DO_WRITE, DO_READ, READ_CAP, SEND, SEND_WAIT.
- IDLE:
  - on rx_valid with CMD_WRITE or CMD_READ, latch the opcode and go to GET_ADDR.
  - on rx_valid with any other byte, set tx_data=RSP_NAK and go to SEND.
- GET_ADDR: on rx_valid, reg_addr<=rx_data. Go to GET_DATA for write, DO_READ for read.
- GET_DATA: on rx_valid, reg_wdata<=rx_data and go to DO_WRITE.
- DO_WRITE: reg_we=1 for one cycle, tx_data<=RSP_ACK, then SEND.
- DO_READ: reg_re=1 for one cycle, then READ_CAP.
- READ_CAP: tx_data<=reg_rdata, then SEND.
- SEND: wait until tx_busy==0, then pulse tx_start and go to SEND_WAIT.
- SEND_WAIT:
  - First cycle: tx_busy is ignored, because uart asserts is_transmitting one cycle after transmit.
  - After that, return to IDLE when tx_busy==0.
- Timeout: 24-bit counter cleared on every accepted rx_valid and while in IDLE. It increments in GET_ADDR and GET_DATA. On reaching TIMEOUT_CYCLES, return to IDLE silently: no strobe, no reply.
- rx_error in GET_ADDR or GET_DATA: abort to IDLE silently. rx_error in any other state is ignored.
- Latency, last byte rx_valid to tx_start with tx_busy low:
  - write: 3 cycles
  - read: 4 cycles
  - unknown opcode: 2 cycles
- overrun: rx_valid in DO_WRITE, DO_READ, READ_CAP, SEND or SEND_WAIT pulses overrun next cycle; the byte is dropped.
- Simultaneous rx_valid and rx_error: rx_error wins, and the byte is discarded.
- Byte ordering: single byte-serial stream, no buffering. The host must wait for the reply before sending the next frame.

Decomposition:
- Package uart_proto_pkg holds:
  - opcode/response constants (CMD_WRITE, CMD_READ, RSP_ACK, RSP_NAK)
  - state encoding localparams (3-bit)
- One natural sub-module, uart_frame_timer: 24-bit inter-byte timeout counter with clear/enable inputs and an expired output.

Test Plan:
1. Write: rx 0x57,0x12,0xA5 spaced 1000 cycles -> reg_we once with reg_addr=0x12, reg_wdata=0xA5; then tx_start once with tx_data=0x4B; busy back to 0.
2. Read: rx 0x52,0x34 with reg_rdata model returning 0x3C -> reg_re once with reg_addr=0x34; tx_data=0x3C at tx_start; no reg_we.
3. Unknown: rx 0x41 -> tx_start with tx_data=0x3F within 2 cycles; no reg_we/reg_re.
4. Timeout: rx 0x57,0x12, then silence TIMEOUT_CYCLES+5 -> IDLE, no strobe, no tx_start; then rx 0x52,0x05 completes normally.
5. Backpressure/overrun: tx_busy held high 200 cycles during a read reply -> exactly one tx_start after tx_busy falls. A byte arriving in SEND -> overrun pulse, no state change.
6. Abort: rx_error after 0x57,0x12 -> IDLE, no reg_we. rst asserted in GET_DATA -> all outputs 0, next frame works.
